// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one result bit per clock, LSB first.
// A result is ready WIDTH+1 clocks after an accepted start. Throughput is one
// result per WIDTH+2 clocks.
// Optional feature: define SERIAL_SUB_OVERFLOW_EN to add o_overflow, the
// two's-complement overflow flag of the subtraction.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_borrow,
`ifdef SERIAL_SUB_OVERFLOW_EN
  output logic             o_overflow,
`endif
  output logic             o_busy,
  output logic             o_done
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic [WIDTH-1:0]  diff_q, diff_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              br_q, br_d;
  logic              borrow_q, borrow_d;
  logic              done_q, done_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic              a_msb_q, a_msb_d;
  logic              b_msb_q, b_msb_d;
  logic              ovf_q, ovf_d;
`endif

  // One full-subtractor cell on the current LSBs.
  logic sub_bit;
  logic sub_br;
  assign sub_bit = a_q[0] ^ b_q[0] ^ br_q;
  assign sub_br  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);

  // Next-state, datapath and completion logic.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    br_d     = br_q;
    borrow_d = borrow_q;
    done_d   = 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    ovf_d    = ovf_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          a_d     = i_a;
          b_d     = i_b;
          br_d    = 1'b0;
          cnt_d   = '0;
          state_d = StShift;
`ifdef SERIAL_SUB_OVERFLOW_EN
          a_msb_d = i_a[WIDTH-1];
          b_msb_d = i_b[WIDTH-1];
`endif
        end
      end
      StShift: begin
        res_d = {sub_bit, res_q[WIDTH-1:1]};
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        br_d  = sub_br;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        diff_d   = res_q;
        borrow_d = br_q;
        done_d   = 1'b1;
        state_d  = StIdle;
`ifdef SERIAL_SUB_OVERFLOW_EN
        ovf_d    = (a_msb_q != b_msb_q) && (res_q[WIDTH-1] != a_msb_q);
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with synchronous reset; reset aborts any operation.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      br_q     <= 1'b0;
      borrow_q <= 1'b0;
      done_q   <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      br_q     <= br_d;
      borrow_q <= borrow_d;
      done_q   <= done_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign o_diff   = diff_q;
  assign o_borrow = borrow_q;
  assign o_busy   = (state_q != StIdle);
  assign o_done   = done_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
  assign o_overflow = ovf_q;
`endif

endmodule
